// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative AES MixColumns engine.
//
// Accepts a 128-bit state over an in_valid/in_ready handshake, transforms
// COLS_PER_CYCLE columns per BUSY cycle (N = 4/COLS_PER_CYCLE cycles), then
// holds the result on out_data until the out_valid/out_ready handshake.
//
// Byte layout: column c = bits [c*32+:32], row 0 byte in [c*32+24+:8],
// row 3 byte in [c*32+:8]. Identical to the inverse MixColumns stage.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   inv        (only with MIXCOL_INV_EN) 1 = inverse coefficients, sampled
//              at the input handshake
//   in_valid   in_data is valid
//   in_ready   engine can accept (IDLE only, low while rst is high)
//   in_data    128-bit input state
//   out_valid  out_data holds a finished result
//   out_ready  consumer accepts result
//   out_data   registered 128-bit result
//   busy       high in BUSY or DONE
//
// Optional feature macro: MIXCOL_INV_EN (adds the inv port and inverse
// MixColumns support). Undefined by default: forward only.

module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1  // legal: 1, 2, 4
) (
  input  logic         clk,
  input  logic         rst,
`ifdef MIXCOL_INV_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned N       = 4 / COLS_PER_CYCLE;
  localparam logic [1:0]  LastCnt = 2'(N - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       state_q;
  logic [1:0]   col_cnt_q;
  logic [127:0] work_q;
  logic [127:0] out_data_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         inv_mode;
  logic [127:0] res_d;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Transform one column (row 0 in bits [31:24]).
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_sel);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] r  [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[(3-i)*8 +: 8];
      m2[i] = xtime(a[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
      m3[i] = m2[i] ^ a[i];
      m9[i] = m8[i] ^ a[i];
      mb[i] = m8[i] ^ m2[i] ^ a[i];
      md[i] = m8[i] ^ m4[i] ^ a[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    if (inv_sel) begin
      r[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end else begin
      r[0] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
      r[1] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
      r[2] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
      r[3] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

`ifdef MIXCOL_INV_EN
  logic inv_q;
  assign inv_mode = inv_q;
`else
  assign inv_mode = 1'b0;
`endif

  // Merge this cycle's freshly transformed columns into the result register.
  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    res_d = out_data_q;
    for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
      idx = 2'(32'(col_cnt_q) * COLS_PER_CYCLE + j);
      res_d[idx*32 +: 32] = mix_col(work_q[idx*32 +: 32], inv_mode);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      col_cnt_q   <= '0;
      work_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MIXCOL_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            work_q    <= in_data;
            col_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StBusy;
`ifdef MIXCOL_INV_EN
            inv_q     <= inv;
`endif
          end
        end
        StBusy: begin
          out_data_q <= res_d;
          if (col_cnt_q == LastCnt) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            col_cnt_q <= col_cnt_q + 2'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by rst so the engine never advertises readiness during reset.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
